// File: rtl/alu_issue_ctrl.sv
// Issue/writeback sequencer for a 32-bit combinational ALU with an 8x32 register file.
// Each command runs IDLE -> EXEC -> WB; one command per three cycles.
module alu_issue_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_op,
  input  logic [2:0]  cmd_rd,
  input  logic [2:0]  cmd_rs1,
  input  logic [2:0]  cmd_rs2,
  input  logic [31:0] cmd_imm,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [2:0]  alu_op,
  input  logic [31:0] alu_r,
  input  logic        alu_z,
  output logic        done,
  output logic [31:0] res_data,
  output logic        res_z,
  output logic        err,
  input  logic [2:0]  dbg_addr,
  output logic [31:0] dbg_data
);

  localparam logic [2:0] OP_LDI = 3'b000;
  localparam logic [2:0] OP_ILL = 3'b111;

  typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;

  state_t      state;
  logic [31:0] regs [8];
  logic [2:0]  rd_q;
  logic [2:0]  op_q;
  logic [31:0] imm_q;

  // Ready is gated by rst_n so nothing is offered while reset is held.
  assign cmd_ready = rst_n && (state == IDLE);
  assign dbg_data  = regs[dbg_addr];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      alu_a    <= '0;
      alu_b    <= '0;
      alu_op   <= '0;
      done     <= 1'b0;
      res_data <= '0;
      res_z    <= 1'b0;
      err      <= 1'b0;
      rd_q     <= '0;
      op_q     <= '0;
      imm_q    <= '0;
      for (int i = 0; i < 8; i++) regs[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (cmd_valid) begin
            alu_a  <= regs[cmd_rs1];
            alu_b  <= regs[cmd_rs2];
            alu_op <= cmd_op;
            rd_q   <= cmd_rd;
            op_q   <= cmd_op;
            imm_q  <= cmd_imm;
            state  <= EXEC;
          end
        end
        EXEC: begin
          // Illegal opcodes still retire (done pulses) but leave all results untouched.
          if (op_q == OP_ILL) begin
            err <= 1'b1;
          end else if (op_q == OP_LDI) begin
            regs[rd_q] <= imm_q;
            res_data   <= imm_q;
            res_z      <= (imm_q == 32'd0);
          end else begin
            regs[rd_q] <= alu_r;
            res_data   <= alu_r;
            res_z      <= alu_z;
          end
          done  <= 1'b1;
          state <= WB;
        end
        WB: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: behavioural ALU on the DUT's outputs, plus an architectural
// register-file model that predicts every result from the opcode rules.
module tb_alu_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_op, cmd_rd, cmd_rs1, cmd_rs2;
  logic [31:0] cmd_imm;
  logic [31:0] alu_a, alu_b;
  logic [2:0]  alu_op;
  logic [31:0] alu_r;
  logic        alu_z;
  logic        done;
  logic [31:0] res_data;
  logic        res_z;
  logic        err;
  logic [2:0]  dbg_addr;
  logic [31:0] dbg_data;

  int errors = 0;
  int checks = 0;

  logic [31:0] m_regs [8];
  logic [31:0] m_res_data;
  logic        m_res_z;
  logic        m_err;
  longint      prev_acc;

  alu_issue_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_rd(cmd_rd), .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2), .cmd_imm(cmd_imm),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_r(alu_r), .alu_z(alu_z),
    .done(done), .res_data(res_data), .res_z(res_z), .err(err),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  // Reference ALU semantics: MUL keeps the low 32 bits, SLT is a signed compare.
  function automatic logic [31:0] alu_fn(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      3'd1:    return a + b;
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return a * b;
      3'd5:    return a - b;
      3'd6:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: return b;
    endcase
  endfunction

  always_comb begin
    alu_r = alu_fn(alu_op, alu_a, alu_b);
    alu_z = (alu_r == 32'd0);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_regs[i] = '0;
    m_res_data = '0;
    m_res_z    = 1'b0;
    m_err      = 1'b0;
  endtask

  task automatic chk_reg(input logic [2:0] idx, input logic [31:0] exp);
    dbg_addr = idx;
    #1;
    chk($sformatf("reg r%0d", idx), dbg_data, exp);
  endtask

  task automatic chk_all_regs();
    @(negedge clk);
    for (int i = 0; i < 8; i++) chk_reg(3'(i), m_regs[i]);
    @(posedge clk);
    #1;
  endtask

  // Issues one command starting just after a posedge; returns just after E2.
  task automatic do_cmd(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                        input logic [2:0] rs2, input logic [31:0] imm, input bit hold, input bit gap);
    logic [31:0] a_exp, b_exp, val;
    int cyc;
    a_exp = m_regs[rs1];
    b_exp = m_regs[rs2];
    cmd_valid = 1'b1;
    cmd_op = op; cmd_rd = rd; cmd_rs1 = rs1; cmd_rs2 = rs2; cmd_imm = imm;
    cyc = 0;
    while (!cmd_ready && cyc < 10) begin
      @(posedge clk); #1; cyc++;
    end
    chk("ready_before_accept", {31'd0, cmd_ready}, 32'd1);
    @(posedge clk);
    if (gap) chk("accept_spacing", 32'($time - prev_acc), 32'd30);
    prev_acc = $time;
    #1;
    if (!hold) begin
      cmd_valid = 1'b0;
      cmd_op = 3'($urandom); cmd_rd = 3'($urandom); cmd_rs1 = 3'($urandom);
      cmd_rs2 = 3'($urandom); cmd_imm = $urandom;
    end
    chk("exec_alu_a", alu_a, a_exp);
    chk("exec_alu_b", alu_b, b_exp);
    chk("exec_alu_op", {29'd0, alu_op}, {29'd0, op});
    chk("exec_ready", {31'd0, cmd_ready}, 32'd0);
    chk("exec_done", {31'd0, done}, 32'd0);
    if (op == 3'b111) begin
      m_err = 1'b1;
    end else begin
      val = (op == 3'b000) ? imm : alu_fn(op, a_exp, b_exp);
      m_regs[rd] = val;
      m_res_data = val;
      m_res_z    = (val == 32'd0);
    end
    @(posedge clk); #1;
    chk("wb_done", {31'd0, done}, 32'd1);
    chk("wb_ready", {31'd0, cmd_ready}, 32'd0);
    chk("wb_res_data", res_data, m_res_data);
    chk("wb_res_z", {31'd0, res_z}, {31'd0, m_res_z});
    chk("wb_err", {31'd0, err}, {31'd0, m_err});
    chk_reg(rd, m_regs[rd]);
    @(posedge clk); #1;
    chk("idle_done", {31'd0, done}, 32'd0);
    chk("idle_ready", {31'd0, cmd_ready}, 32'd1);
  endtask

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_rd = '0; cmd_rs1 = '0;
    cmd_rs2 = '0; cmd_imm = '0; dbg_addr = '0; prev_acc = 0;
    model_reset();

    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", {31'd0, cmd_ready}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_alu_a", alu_a, 32'd0);
    chk("rst_alu_b", alu_b, 32'd0);
    chk("rst_alu_op", {29'd0, alu_op}, 32'd0);
    chk("rst_res_data", res_data, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk_all_regs();
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("ready_after_reset", {31'd0, cmd_ready}, 32'd1);

    do_cmd(3'd0, 3'd1, 3'd0, 3'd0, 32'd5, 0, 0);
    do_cmd(3'd0, 3'd2, 3'd0, 3'd0, 32'd3, 0, 0);
    chk_reg(3'd1, 32'd5);
    chk_reg(3'd2, 32'd3);
    do_cmd(3'd1, 3'd3, 3'd1, 3'd2, 32'd0, 0, 0);
    chk_reg(3'd3, 32'd8);
    chk("add_res_z", {31'd0, res_z}, 32'd0);
    do_cmd(3'd5, 3'd4, 3'd1, 3'd2, 32'd0, 0, 0);
    chk_reg(3'd4, 32'd2);
    do_cmd(3'd4, 3'd5, 3'd1, 3'd2, 32'd0, 0, 0);
    chk_reg(3'd5, 32'd15);
    do_cmd(3'd6, 3'd6, 3'd2, 3'd1, 32'd0, 0, 0);
    chk_reg(3'd6, 32'd1);
    do_cmd(3'd5, 3'd7, 3'd1, 3'd1, 32'd0, 0, 0);
    chk_reg(3'd7, 32'd0);
    chk("sub_zero_res_z", {31'd0, res_z}, 32'd1);
    do_cmd(3'd0, 3'd0, 3'd0, 3'd0, 32'd0, 0, 0);
    chk_reg(3'd0, 32'd0);
    chk("ldi_zero_res_z", {31'd0, res_z}, 32'd1);

    // Dependent chain with cmd_valid held high across done.
    do_cmd(3'd0, 3'd1, 3'd0, 3'd0, 32'd7, 1, 0);
    do_cmd(3'd1, 3'd2, 3'd1, 3'd1, 32'd0, 1, 1);
    do_cmd(3'd2, 3'd3, 3'd2, 3'd1, 32'd0, 0, 1);
    chk_reg(3'd2, 32'd14);
    chk_reg(3'd3, 32'd6);

    do_cmd(3'd7, 3'd1, 3'd2, 3'd3, 32'hDEAD_BEEF, 0, 0);
    chk_reg(3'd1, 32'd7);
    chk("illegal_res_data", res_data, 32'd6);
    chk("illegal_err", {31'd0, err}, 32'd1);
    do_cmd(3'd0, 3'd4, 3'd0, 3'd0, 32'd9, 0, 0);
    chk("err_sticky", {31'd0, err}, 32'd1);

    for (int n = 0; n < 40; n++) begin
      do_cmd(3'($urandom_range(0, 7)), 3'($urandom), 3'($urandom), 3'($urandom),
             ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom, bit'($urandom_range(0, 1)), 0);
    end
    cmd_valid = 1'b0;
    chk_all_regs();

    // Reset during EXEC must abort the command and clear everything.
    do_cmd(3'd0, 3'd1, 3'd0, 3'd0, 32'd5, 0, 0);
    do_cmd(3'd0, 3'd2, 3'd0, 3'd0, 32'd3, 0, 0);
    cmd_valid = 1'b1; cmd_op = 3'd1; cmd_rd = 3'd3; cmd_rs1 = 3'd1; cmd_rs2 = 3'd2;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    chk("abort_exec_alu_a", alu_a, 32'd5);
    @(negedge clk); rst_n = 1'b0;
    model_reset();
    @(posedge clk); #1;
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_ready", {31'd0, cmd_ready}, 32'd0);
    chk("abort_alu_a", alu_a, 32'd0);
    chk("abort_alu_b", alu_b, 32'd0);
    chk("abort_alu_op", {29'd0, alu_op}, 32'd0);
    chk("abort_res_data", res_data, 32'd0);
    chk("abort_res_z", {31'd0, res_z}, 32'd0);
    chk("abort_err", {31'd0, err}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("abort_ready_after", {31'd0, cmd_ready}, 32'd1);
    chk("abort_no_done", {31'd0, done}, 32'd0);
    chk_reg(3'd3, 32'd0);
    chk_all_regs();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
